flash_therm_encoder: RTL and testbench
======================================

FLASH_THERM_ENCODER -- requirements
Module: flash_therm_encoder

Interface
REQ-001 The block SHALL have parameter N_CMP, default 32, giving the comparator count; legal range is 8..32.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the output FIFO depth; it is a power of two, minimum 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port q, input, N_CMP bits: raw comparator thermometer outputs (bit 0 is the lowest threshold).
REQ-006 The block SHALL have port cal_rdy, input, 1 bit: calibration controller ready; samples are legal only while high.
REQ-007 The block SHALL have port sample_en, input, 1 bit: capture strobe, one sample per high cycle.
REQ-008 The block SHALL have port out_data, output, 6 bits: conversion code 0..N_CMP.
REQ-009 The block SHALL have port out_or, output, 1 bit: over-range, meaning code == N_CMP.
REQ-010 The block SHALL have port out_ur, output, 1 bit: under-range, meaning code == 0.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_data/out_or/out_ur hold a FIFO head entry.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer accepts the head entry when out_valid && out_ready at a rising edge.
REQ-013 The block SHALL have port ovf, output, 1 bit: sticky flag set when a sample is dropped because the FIFO is full.
REQ-014 The block SHALL have port bubble_cnt, output, 16 bits: saturating count of samples altered by bubble correction.
REQ-015 The block SHALL have port clr, input, 1 bit: synchronous clear of ovf and bubble_cnt.

Function
REQ-016 The block SHALL process data through pipeline stages S1, S2, S3 and then the FIFO: S1 registers q when sample_en && cal_rdy; S2 applies correction; S3 encodes; the FIFO write occurs on the following edge.
REQ-017 The block SHALL have a latency such that, with the FIFO empty, a sample captured at edge k gives out_valid high after edge k+3.
REQ-018 Each stage SHALL carry a valid bit, and stages SHALL advance unconditionally, with no backpressure into the pipeline.
REQ-019 Correction SHALL compute c[i] = majority(q[i-1], q[i], q[i+1]), with q[-1]=1 and q[N_CMP]=0.
REQ-020 Encoding SHALL produce code = population count of the corrected vector, zero-extended to 6 bits.
REQ-021 out_or and out_ur SHALL be computed in S3 and stored alongside the code, giving a 6+2 bit FIFO entry.
REQ-022 bubble_cnt SHALL increment once per S2-valid sample where the corrected vector != the raw vector, and SHALL saturate at 0xFFFF.
REQ-023 When the FIFO is full and S3 is valid, the entry SHALL be dropped and ovf set, unless a read occurs in the same cycle, in which case the write is accepted.
REQ-024 A simultaneous read and write on a non-full, non-empty FIFO SHALL leave the occupancy unchanged.
REQ-025 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, with one extra bit used for full/empty detection.
REQ-026 When cal_rdy falls, the S1..S3 valid bits SHALL clear on the next edge (flush) while FIFO contents are kept.
REQ-027 sample_en SHALL be ignored while cal_rdy is low.
REQ-028 clr SHALL take priority over a same-cycle ovf set or bubble_cnt increment.
REQ-029 out_data, out_or and out_ur SHALL be driven from the FIFO head and SHALL be 0 when the FIFO is empty.

Reset
REQ-030 rst_n low SHALL asynchronously clear all stage valid bits, the FIFO pointers, ovf and bubble_cnt.
REQ-031 During reset all outputs SHALL be 0.
REQ-032 A reset asserted mid-operation SHALL discard in-flight and buffered samples.
REQ-033 After reset release, the first capture SHALL be possible on the first edge where sample_en && cal_rdy is high.

Configuration
REQ-034 Macro FLASH_ENC_BUBBLE_CORR_EN defined SHALL enable the behaviour of REQ-019 and REQ-022.
REQ-035 Macro FLASH_ENC_BUBBLE_CORR_EN undefined SHALL make S2 a pure register stage (corrected = raw), hold bubble_cnt at 0, and leave the latency unchanged.

Structure
REQ-036 Shared package flash_adc_pkg SHALL hold the N_CMP default, the CODE_W=6 constant and the fifo_entry_t struct {code, or_flag, ur_flag}.
REQ-037 The FIFO SHALL be a separate sub-module, flash_enc_fifo, parameterised by FIFO_DEPTH and the entry type.

Verification
REQ-038 Bench scenario: q=0x0000FFFF, one sample, out_ready=1 -> out_data=16 after edge k+3, out_or=0, out_ur=0.
REQ-039 Bench scenario: q=0x0000FF7F with the macro on -> out_data=16 and bubble_cnt=1; with the macro off -> out_data=15 and bubble_cnt=0.
REQ-040 Bench scenario: q=0xFFFFFFFF then q=0x00000000 -> codes 32 (out_or=1) then 0 (out_ur=1).
REQ-041 Bench scenario: out_ready=0, six consecutive samples, FIFO_DEPTH=4 -> 4 entries held, ovf=1; clr pulse -> ovf=0.
REQ-042 Bench scenario: FIFO full, out_ready=1 and an S3-valid write in the same cycle -> no drop, ovf stays 0, occupancy stays 4.
REQ-043 Bench scenario: 3 samples issued then cal_rdy dropped one cycle later -> at most 1 sample reaches the FIFO, no later out_valid; rst_n pulse mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/flash_adc_pkg.sv
// Shared constants and the FIFO entry type for the flash ADC thermometer encoder.
package flash_adc_pkg;

    localparam int unsigned N_CMP_DEF = 32;
    localparam int unsigned CODE_W    = 6;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              or_flag;
        logic              ur_flag;
    } fifo_entry_t;

endpackage

// File: rtl/flash_enc_fifo.sv
// Output FIFO: power-of-two depth, extra pointer bit for full/empty, head zeroed when empty.
module flash_enc_fifo
    import flash_adc_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter type entry_t = fifo_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   wr_en_i,
    input  entry_t wr_data_i,
    input  logic   rd_en_i,
    output entry_t rd_data_o,
    output logic   empty_o,
    output logic   full_o,
    output logic   drop_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    entry_t      mem_q [FIFO_DEPTH];
    logic        rd_fire;
    logic        wr_fire;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A read in the same cycle frees the slot the write lands in, so a full FIFO still accepts.
    assign rd_fire = rd_en_i && !empty_o;
    assign wr_fire = wr_en_i && (!full_o || rd_fire);
    assign drop_o  = wr_en_i && !wr_fire;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(wr_fire);
        rd_ptr_d = rd_ptr_q + (AW+1)'(rd_fire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/flash_therm_encoder.sv
// Flash ADC thermometer-to-binary encoder: capture, bubble correction, popcount, output FIFO.
// Define FLASH_ENC_BUBBLE_CORR_EN to enable majority-of-three bubble correction and counting.
module flash_therm_encoder
    import flash_adc_pkg::*;
#(
    parameter int unsigned N_CMP      = N_CMP_DEF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CMP-1:0]  q,
    input  logic              cal_rdy,
    input  logic              sample_en,
    output logic [CODE_W-1:0] out_data,
    output logic              out_or,
    output logic              out_ur,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              ovf,
    output logic [15:0]       bubble_cnt,
    input  logic              clr
);

    logic              s1_v_q, s2_v_q, s3_v_q;
    logic [N_CMP-1:0]  s1_data_q, s2_data_q;
    logic [N_CMP-1:0]  corr_d;
    logic              bub_d, s2_bub_q;
    logic [CODE_W-1:0] code_d;
    fifo_entry_t       s3_d, s3_q;
    fifo_entry_t       head;
    logic              fifo_empty, fifo_full, fifo_drop;
    logic              ovf_q;
    logic [15:0]       bub_cnt_q;

`ifdef FLASH_ENC_BUBBLE_CORR_EN
    logic [N_CMP+1:0]  qext;

    // Edges of the ladder are pinned: below bit 0 reads 1, above the top reads 0.
    always_comb begin
        qext = {1'b0, s1_data_q, 1'b1};
        corr_d = '0;
        for (int unsigned i = 0; i < N_CMP; i++) begin
            corr_d[i] = (qext[i] & qext[i+1]) | (qext[i+1] & qext[i+2]) | (qext[i] & qext[i+2]);
        end
        bub_d = (corr_d != s1_data_q);
    end
`else
    always_comb begin
        corr_d = s1_data_q;
        bub_d  = 1'b0;
    end
`endif

    always_comb begin
        code_d = '0;
        for (int unsigned i = 0; i < N_CMP; i++) begin
            code_d = code_d + CODE_W'(s2_data_q[i]);
        end
        s3_d.code    = code_d;
        s3_d.or_flag = (code_d == CODE_W'(N_CMP));
        s3_d.ur_flag = (code_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            s3_v_q    <= 1'b0;
            s1_data_q <= '0;
            s2_data_q <= '0;
            s2_bub_q  <= 1'b0;
            s3_q      <= '0;
        end else begin
            // Valid bits drop while cal_rdy is low, flushing the pipe without touching the FIFO.
            s1_v_q   <= sample_en && cal_rdy;
            s2_v_q   <= s1_v_q && cal_rdy;
            s3_v_q   <= s2_v_q && cal_rdy;
            if (sample_en && cal_rdy) begin
                s1_data_q <= q;
            end
            s2_data_q <= corr_d;
            s2_bub_q  <= bub_d;
            s3_q      <= s3_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q     <= 1'b0;
            bub_cnt_q <= '0;
        end else if (clr) begin
            ovf_q     <= 1'b0;
            bub_cnt_q <= '0;
        end else begin
            if (fifo_drop) begin
                ovf_q <= 1'b1;
            end
            if (s2_v_q && s2_bub_q && (bub_cnt_q != '1)) begin
                bub_cnt_q <= bub_cnt_q + 16'd1;
            end
        end
    end

    flash_enc_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .entry_t    (fifo_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (s3_v_q),
        .wr_data_i (s3_q),
        .rd_en_i   (out_ready),
        .rd_data_o (head),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .drop_o    (fifo_drop)
    );

    assign out_valid  = !fifo_empty;
    assign out_data   = head.code;
    assign out_or     = head.or_flag;
    assign out_ur     = head.ur_flag;
    assign ovf        = ovf_q;
    assign bubble_cnt = bub_cnt_q;

endmodule

// File: tb/tb_flash_therm_encoder.sv
// Directed self-checking bench for flash_therm_encoder (N_CMP=32, FIFO_DEPTH=4).
module tb_flash_therm_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] q;
    logic        cal_rdy;
    logic        sample_en;
    logic [5:0]  out_data;
    logic        out_or;
    logic        out_ur;
    logic        out_valid;
    logic        out_ready;
    logic        ovf;
    logic [15:0] bubble_cnt;
    logic        clr;

    int checks   = 0;
    int failures = 0;

`ifdef FLASH_ENC_BUBBLE_CORR_EN
    localparam logic [5:0]  EXP_BUB_CODE = 6'd16;
    localparam logic [15:0] EXP_BUB_CNT  = 16'd1;
`else
    localparam logic [5:0]  EXP_BUB_CODE = 6'd15;
    localparam logic [15:0] EXP_BUB_CNT  = 16'd0;
`endif

    always #5 clk = ~clk;

    flash_therm_encoder #(
        .N_CMP      (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .q          (q),
        .cal_rdy    (cal_rdy),
        .sample_en  (sample_en),
        .out_data   (out_data),
        .out_or     (out_or),
        .out_ur     (out_ur),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ovf        (ovf),
        .bubble_cnt (bubble_cnt),
        .clr        (clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [31:0] v);
        q = v;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_or, out_ur, ovf, bubble_cnt} !== 26'd0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%0b d=%0d or=%0b ur=%0b ovf=%0b bc=%0d expected all 0",
                     out_valid, out_data, out_or, out_ur, ovf, bubble_cnt);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({out_valid, out_data, out_or, out_ur, ovf, bubble_cnt} !== 26'd0) begin
            failures++;
            $display("FAIL post_reset_idle: got v=%0b d=%0d ovf=%0b bc=%0d expected all 0",
                     out_valid, out_data, ovf, bubble_cnt);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        capture(32'h0000FFFF);
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_early: got out_valid=%0b at k+2 expected 0", out_valid);
        end
        tick();
        checks++;
        if ({out_valid, out_data, out_or, out_ur} !== {1'b1, 6'd16, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL basic_code: got v=%0b d=%0d or=%0b ur=%0b expected v=1 d=16 or=0 ur=0",
                     out_valid, out_data, out_or, out_ur);
        end
        tick();
        checks++;
        if ({out_valid, out_data, out_or, out_ur} !== 9'd0) begin
            failures++;
            $display("FAIL empty_zero: got v=%0b d=%0d or=%0b ur=%0b expected all 0",
                     out_valid, out_data, out_or, out_ur);
        end
    endtask

    task automatic test_bubble();
        out_ready = 1'b1;
        capture(32'h0000FF7F);
        tick();
        tick();
        tick();
        checks++;
        if ({out_valid, out_data} !== {1'b1, EXP_BUB_CODE}) begin
            failures++;
            $display("FAIL bubble_code: got v=%0b d=%0d expected v=1 d=%0d", out_valid, out_data, EXP_BUB_CODE);
        end
        checks++;
        if (bubble_cnt !== EXP_BUB_CNT) begin
            failures++;
            $display("FAIL bubble_cnt: got %0d expected %0d", bubble_cnt, EXP_BUB_CNT);
        end
        tick();
    endtask

    task automatic test_range();
        out_ready = 1'b1;
        capture(32'hFFFFFFFF);
        capture(32'h00000000);
        tick();
        tick();
        checks++;
        if ({out_valid, out_data, out_or, out_ur} !== {1'b1, 6'd32, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL range_over: got v=%0b d=%0d or=%0b ur=%0b expected v=1 d=32 or=1 ur=0",
                     out_valid, out_data, out_or, out_ur);
        end
        tick();
        checks++;
        if ({out_valid, out_data, out_or, out_ur} !== {1'b1, 6'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL range_under: got v=%0b d=%0d or=%0b ur=%0b expected v=1 d=0 or=0 ur=1",
                     out_valid, out_data, out_or, out_ur);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL range_drain: got out_valid=%0b expected 0", out_valid);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            v = (32'd1 << i) - 32'd1;
            capture(v);
        end
        tick();
        tick();
        tick();
        checks++;
        if ({ovf, out_valid, out_data} !== {1'b1, 1'b1, 6'd1}) begin
            failures++;
            $display("FAIL ovf_set: got ovf=%0b v=%0b d=%0d expected ovf=1 v=1 d=1", ovf, out_valid, out_data);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if ({ovf, bubble_cnt} !== 17'd0) begin
            failures++;
            $display("FAIL clr: got ovf=%0b bc=%0d expected ovf=0 bc=0", ovf, bubble_cnt);
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if ({out_valid, out_data} !== {1'b1, 6'(i)}) begin
                failures++;
                $display("FAIL ovf_drain_%0d: got v=%0b d=%0d expected v=1 d=%0d", i, out_valid, out_data, i);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovf_occupancy: got out_valid=%0b after 4 reads expected 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_full_rw();
        logic [31:0] v;
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            v = (32'd1 << i) - 32'd1;
            capture(v);
        end
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL full_rw_ovf: got ovf=%0b expected 0", ovf);
        end
        out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            checks++;
            if ({out_valid, out_data} !== {1'b1, 6'(i)}) begin
                failures++;
                $display("FAIL full_rw_drain_%0d: got v=%0b d=%0d expected v=1 d=%0d", i, out_valid, out_data, i);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_rw_occupancy: got out_valid=%0b after 4 reads expected 0", out_valid);
        end
    endtask

    task automatic test_flush();
        int seen;
        logic [5:0] first_code;
        seen = 0;
        first_code = '0;
        out_ready = 1'b1;
        capture(32'h0000007F);
        capture(32'h000000FF);
        capture(32'h000001FF);
        cal_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) begin
                if (seen == 0) first_code = out_data;
                seen++;
            end
        end
        checks++;
        if (seen > 1) begin
            failures++;
            $display("FAIL flush_count: got %0d entries expected at most 1", seen);
        end
        if (seen == 1) begin
            checks++;
            if (first_code !== 6'd7) begin
                failures++;
                $display("FAIL flush_code: got %0d expected 7", first_code);
            end
        end
        seen = 0;
        capture(32'h0000FFFF);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL sample_ignored: got %0d entries with cal_rdy low expected 0", seen);
        end
        cal_rdy = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        int seen;
        out_ready = 1'b0;
        capture(32'h0000FF7F);
        for (int i = 2; i <= 8; i++) begin
            v = (32'd1 << i) - 32'd1;
            capture(v);
        end
        checks++;
        if ({ovf, out_valid} !== 2'b11) begin
            failures++;
            $display("FAIL pre_reset_state: got ovf=%0b v=%0b expected ovf=1 v=1", ovf, out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_or, out_ur, ovf, bubble_cnt} !== 26'd0) begin
            failures++;
            $display("FAIL mid_reset: got v=%0b d=%0d or=%0b ur=%0b ovf=%0b bc=%0d expected all 0",
                     out_valid, out_data, out_or, out_ur, ovf, bubble_cnt);
        end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        capture(32'h0000000F);
        seen = 0;
        tick();
        if (out_valid) seen++;
        tick();
        if (out_valid) seen++;
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_discard: got %0d stale entries expected 0", seen);
        end
        tick();
        checks++;
        if ({out_valid, out_data} !== {1'b1, 6'd4}) begin
            failures++;
            $display("FAIL first_capture: got v=%0b d=%0d expected v=1 d=4", out_valid, out_data);
        end
        tick();
    endtask

    initial begin
        rst_n     = 1'b1;
        q         = '0;
        cal_rdy   = 1'b1;
        sample_en = 1'b0;
        out_ready = 1'b0;
        clr       = 1'b0;
        test_reset();
        test_basic();
        test_bubble();
        test_range();
        test_overflow();
        test_full_rw();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
